// File: rtl/numdisp_pkg.sv
// numdisp_pkg: shared types and constants for the number display sprite.
//   ROM_LATENCY  read latency of the glyph BROM, in pixel clocks
//   PIX_LATENCY  counters-in to draw_out latency, in pixel clocks
//   conv_state_t state encoding of the binary-to-BCD sequencer
//   bcd_digit_t  one decimal digit
//   rom_addr_w() glyph ROM address width
//   glyph_bit()  glyph ROM contents: a seven-segment font, glyphs 0-9
//                stacked, row-major, evaluated at elaboration time
package numdisp_pkg;

    localparam int ROM_LATENCY = 2;
    localparam int PIX_LATENCY = 3;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} conv_state_t;

    typedef logic [3:0] bcd_digit_t;

    function automatic int rom_addr_w(input int glyph_w, input int glyph_h, input int num_glyphs);
        return $clog2(glyph_w * glyph_h * num_glyphs);
    endfunction

    // Segment bits: 0=a(top) 1=b(top right) 2=c(bottom right) 3=d(bottom)
    // 4=e(bottom left) 5=f(top left) 6=g(middle).
    function automatic logic [6:0] seg_mask(input int unsigned d);
        case (d)
            0:       return 7'h3F;
            1:       return 7'h06;
            2:       return 7'h5B;
            3:       return 7'h4F;
            4:       return 7'h66;
            5:       return 7'h6D;
            6:       return 7'h7D;
            7:       return 7'h07;
            8:       return 7'h7F;
            9:       return 7'h6F;
            default: return 7'h00;
        endcase
    endfunction

    // Stroke thickness is 1/8 of the glyph size; horizontal strokes span
    // the full width so that glyphs like 7 and 1 differ in the top row.
    function automatic logic glyph_bit(input int unsigned a, input int unsigned w,
                                       input int unsigned h);
        int unsigned d, r, gx, gy, tx, ty, mid;
        logic [6:0]  s;
        d   = a / (w * h);
        r   = a % (w * h);
        gy  = r / w;
        gx  = r % w;
        tx  = (w / 8 > 0) ? w / 8 : 1;
        ty  = (h / 8 > 0) ? h / 8 : 1;
        mid = (h - ty) / 2;
        s   = seg_mask(d);
        return (s[0] && gy < ty)
            || (s[1] && gx >= w - tx && gy <  h / 2)
            || (s[2] && gx >= w - tx && gy >= h / 2)
            || (s[3] && gy >= h - ty)
            || (s[4] && gx <  tx     && gy >= h / 2)
            || (s[5] && gx <  tx     && gy <  h / 2)
            || (s[6] && gy >= mid    && gy <  mid + ty);
    endfunction

endpackage

// File: rtl/bin_to_bcd_seq.sv
// bin_to_bcd_seq: sequential double-dabble converter with a one-deep
// pending request and saturation to all nines.
//   clk, rst_n  clock, asynchronous active-low reset
//   value, load latch value on load (queued as pending while busy)
//   busy        conversion in progress (SHIFT and DONE)
//   digits      displayed digits, index 0 = leftmost (most significant)
//   blank       per-digit blank mask, registered with digits
// Macro NUMDISP_LZB_EN: when defined, blank marks leading zeros (never the
// rightmost digit); otherwise blank is all zeros.
module bin_to_bcd_seq
    import numdisp_pkg::*;
#(
    parameter int VALUE_W = 14,
    parameter int DIGITS  = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [VALUE_W-1:0] value,
    input  logic               load,
    output logic               busy,
    output bcd_digit_t         digits [DIGITS],
    output logic [DIGITS-1:0]  blank
);

    localparam int CNT_W = (VALUE_W > 1) ? $clog2(VALUE_W) : 1;
    localparam int BW    = DIGITS * 4;

    function automatic longint unsigned pow10(input int n);
        longint unsigned r;
        r = 1;
        for (int i = 0; i < n; i++) r = r * 10;
        return r;
    endfunction

    localparam longint unsigned LIMIT = pow10(DIGITS);

    function automatic logic over_range(input logic [VALUE_W-1:0] v);
        return 64'(v) >= LIMIT;
    endfunction

    function automatic logic [BW-1:0] dabble_adjust(input logic [BW-1:0] b);
        logic [BW-1:0] r;
        r = b;
        for (int i = 0; i < DIGITS; i++)
            if (r[i*4 +: 4] >= 4'd5) r[i*4 +: 4] = r[i*4 +: 4] + 4'd3;
        return r;
    endfunction

    // Leading zeros scanned from the left; the rightmost digit is never blank.
    function automatic logic [DIGITS-1:0] lz_mask(input logic [BW-1:0] b);
        logic [DIGITS-1:0] m;
        logic              lead;
        m    = '0;
        lead = 1'b1;
        for (int k = 0; k < DIGITS - 1; k++) begin
            lead = lead && (b[(DIGITS-1-k)*4 +: 4] == 4'd0);
            m[k] = lead;
        end
        return m;
    endfunction

`ifdef NUMDISP_LZB_EN
    localparam logic [DIGITS-1:0] RESET_BLANK = lz_mask('0);
`else
    localparam logic [DIGITS-1:0] RESET_BLANK = '0;
`endif

    conv_state_t        state;
    logic [CNT_W-1:0]   cnt;
    logic [VALUE_W-1:0] shreg;
    logic [BW-1:0]      acc;
    logic [BW-1:0]      adj;
    logic               sat;
    logic               pend_vld;
    logic [VALUE_W-1:0] pend_val;

    assign adj = dabble_adjust(acc);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            busy     <= 1'b0;
            cnt      <= '0;
            sat      <= 1'b0;
            pend_vld <= 1'b0;
            blank    <= RESET_BLANK;
            for (int k = 0; k < DIGITS; k++) digits[k] <= '0;
        end else begin
            case (state)
                IDLE: begin
                    // a fresh load is newer than anything pending
                    if (load || pend_vld) begin
                        shreg    <= load ? value : pend_val;
                        sat      <= over_range(load ? value : pend_val);
                        acc      <= '0;
                        cnt      <= '0;
                        busy     <= 1'b1;
                        pend_vld <= 1'b0;
                        state    <= SHIFT;
                    end
                end
                SHIFT: begin
                    acc   <= {adj[BW-2:0], shreg[VALUE_W-1]};
                    shreg <= shreg << 1;
                    cnt   <= cnt + 1'b1;
                    if (cnt == CNT_W'(VALUE_W - 1)) state <= DONE;
                end
                DONE: begin
                    for (int k = 0; k < DIGITS; k++)
                        digits[k] <= sat ? 4'd9 : acc[(DIGITS-1-k)*4 +: 4];
`ifdef NUMDISP_LZB_EN
                    blank <= sat ? '0 : lz_mask(acc);
`else
                    blank <= '0;
`endif
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
            // requests while busy (including the DONE cycle) overwrite pending
            if (load && state != IDLE) begin
                pend_val <= value;
                pend_vld <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/numdisp_brom.sv
// numdisp_brom: 1-bit single-port glyph ROM, two-cycle registered read.
//   clk   clock
//   addr  pixel address (glyph * W * H + row * W + col)
//   data  pixel bit, valid two clocks after addr
module numdisp_brom
    import numdisp_pkg::*;
#(
    parameter int GLYPH_W    = 24,
    parameter int GLYPH_H    = 24,
    parameter int NUM_GLYPHS = 10,
    parameter int AW         = 13
) (
    input  logic          clk,
    input  logic [AW-1:0] addr,
    output logic          data
);

    localparam int DEPTH = GLYPH_W * GLYPH_H * NUM_GLYPHS;

    logic [DEPTH-1:0] mem;
    logic             rd_p1;

    for (genvar a = 0; a < DEPTH; a++) begin : g_rom
        assign mem[a] = glyph_bit(a, GLYPH_W, GLYPH_H);
    end

    // array read register, then output register
    always_ff @(posedge clk) begin
        rd_p1 <= mem[addr];
        data  <= rd_p1;
    end

endmodule

// File: rtl/number_display_sprite.sv
// number_display_sprite: draws an unsigned value as DIGITS decimal glyphs
// at (x_in, y_in), scaled by 2^SCALE_LOG2, with draw_out three clocks
// behind hcount_in/vcount_in.
//   pixel_clk_in, rst_n_in  clock, asynchronous active-low reset
//   x_in, y_in              top-left corner of the digit field
//   hcount_in, vcount_in    current pixel position
//   value_in, load_in       value to display, single-cycle latch request
//   busy_out                conversion in progress
//   draw_out                glyph pixel set at the pipelined position
// Macro NUMDISP_LZB_EN: leading-zero blanking (see bin_to_bcd_seq).
module number_display_sprite
    import numdisp_pkg::*;
#(
    parameter int DIGITS     = 4,
    parameter int VALUE_W    = 14,
    parameter int GLYPH_W    = 24,
    parameter int GLYPH_H    = 24,
    parameter int NUM_GLYPHS = 10,
    parameter int SCALE_LOG2 = 0
) (
    input  logic               pixel_clk_in,
    input  logic               rst_n_in,
    input  logic [10:0]        x_in,
    input  logic [9:0]         y_in,
    input  logic [10:0]        hcount_in,
    input  logic [9:0]         vcount_in,
    input  logic [VALUE_W-1:0] value_in,
    input  logic               load_in,
    output logic               busy_out,
    output logic               draw_out
);

    localparam int          AW         = rom_addr_w(GLYPH_W, GLYPH_H, NUM_GLYPHS);
    localparam int          KW         = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int unsigned CELL_W     = GLYPH_W << SCALE_LOG2;
    localparam int unsigned CELL_H     = GLYPH_H << SCALE_LOG2;
    localparam int unsigned FIELD_W    = DIGITS * CELL_W;
    localparam int unsigned GLYPH_AREA = GLYPH_W * GLYPH_H;

    bcd_digit_t              digits [DIGITS];
    logic [DIGITS-1:0]       blank;
    logic [10:0]             dx;
    logic [9:0]              dy;
    logic [31:0]             dx_u, dy_u;
    logic [KW-1:0]           k;
    logic [31:0]             k_off, gx, gy, addr_full;
    logic                    in_field;
    logic [AW-1:0]           addr_c;
    logic [AW-1:0]           addr_p1;
    logic                    fld_p1;
    logic [ROM_LATENCY-1:0]  fld_dly;
    logic                    rom_bit;

    bin_to_bcd_seq #(
        .VALUE_W (VALUE_W),
        .DIGITS  (DIGITS)
    ) u_bcd (
        .clk    (pixel_clk_in),
        .rst_n  (rst_n_in),
        .value  (value_in),
        .load   (load_in),
        .busy   (busy_out),
        .digits (digits),
        .blank  (blank)
    );

    // Stage 0: position to glyph address. dx/dy wrap when left of or above
    // the field; the explicit >= compares reject those positions.
    assign dx   = hcount_in - x_in;
    assign dy   = vcount_in - y_in;
    assign dx_u = 32'(dx);
    assign dy_u = 32'(dy);

    always_comb begin
        k = '0;
        for (int unsigned j = 1; j < DIGITS; j++)
            if (dx_u >= j * CELL_W) k = KW'(j);
        k_off     = 32'(k) * CELL_W;
        gx        = (dx_u - k_off) >> SCALE_LOG2;
        gy        = dy_u >> SCALE_LOG2;
        addr_full = 32'(digits[k]) * GLYPH_AREA + gy * GLYPH_W + gx;
        in_field  = (hcount_in >= x_in) && (dx_u < FIELD_W)
                 && (vcount_in >= y_in) && (dy_u < CELL_H) && !blank[k];
        addr_c    = in_field ? AW'(addr_full) : '0;
    end

    // Stage 1: registered address and field flag
    always_ff @(posedge pixel_clk_in) begin
        addr_p1 <= addr_c;
    end

    numdisp_brom #(
        .GLYPH_W    (GLYPH_W),
        .GLYPH_H    (GLYPH_H),
        .NUM_GLYPHS (NUM_GLYPHS),
        .AW         (AW)
    ) u_rom (
        .clk  (pixel_clk_in),
        .addr (addr_p1),
        .data (rom_bit)
    );

    // Stages 2-3: field flag follows the ROM read, then the output register
    always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            fld_p1   <= 1'b0;
            fld_dly  <= '0;
            draw_out <= 1'b0;
        end else begin
            fld_p1   <= in_field;
            fld_dly  <= {fld_dly[ROM_LATENCY-2:0], fld_p1};
            draw_out <= fld_dly[ROM_LATENCY-1] && rom_bit;
        end
    end

endmodule

// File: tb/tb_number_display_sprite.sv
module tb_number_display_sprite;
    import numdisp_pkg::*;

`ifdef NUMDISP_LZB_EN
    localparam bit LZB = 1'b1;
`else
    localparam bit LZB = 1'b0;
`endif
    localparam int X0 = 100;
    localparam int Y0 = 50;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [10:0] x, h;
    logic [9:0]  y, v;
    logic [13:0] val;
    logic        load;
    logic        busy0, draw0, busy1, draw1;

    always #5 clk = ~clk;

    number_display_sprite #(.SCALE_LOG2(0)) dut0 (
        .pixel_clk_in (clk), .rst_n_in (rst_n), .x_in (x), .y_in (y),
        .hcount_in (h), .vcount_in (v), .value_in (val), .load_in (load),
        .busy_out (busy0), .draw_out (draw0)
    );

    number_display_sprite #(.SCALE_LOG2(1)) dut1 (
        .pixel_clk_in (clk), .rst_n_in (rst_n), .x_in (x), .y_in (y),
        .hcount_in (h), .vcount_in (v), .value_in (val), .load_in (load),
        .busy_out (busy1), .draw_out (draw1)
    );

    typedef struct {
        int    due;
        int    inst;
        bit    exp;
        string name;
    } pix_t;

    pix_t pq[$];
    int   cq[$];
    int   ecount = 0;
    int   n_checks = 0;
    int   n_fails = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int disp_value();
        int r;
        r = 0;
        for (int k = 0; k < 4; k++) r = r * 10 + int'(dut0.u_bcd.digits[k]);
        return r;
    endfunction

    initial forever begin
        @(posedge clk);
        ecount++;
    end

    // Monitor: pixel results due this cycle, and completed conversions.
    initial begin : monitor
        bit   prev_busy;
        int   busy_len;
        int   e;
        pix_t p;
        prev_busy = 1'b0;
        busy_len  = 0;
        forever begin
            @(negedge clk);
            while (pq.size() > 0 && pq[0].due <= ecount) begin
                p = pq.pop_front();
                check(p.name, int'(p.inst == 1 ? draw1 : draw0), int'(p.exp));
            end
            if (!rst_n) begin
                prev_busy = 1'b0;
                busy_len  = 0;
            end else begin
                if (busy0) busy_len++;
                if (prev_busy && !busy0) begin
                    if (cq.size() == 0) begin
                        check("spurious_conversion", cq.size(), 1);
                    end else begin
                        e = cq.pop_front();
                        check("digits", disp_value(), e);
                        check("busy_len", busy_len, 15);
                    end
                    busy_len = 0;
                end
                prev_busy = busy0;
            end
        end
    end

    task automatic pix(input int inst, input int hh, input int vv, input bit e, input string name);
        h = 11'(hh);
        v = 10'(vv);
        pq.push_back('{ecount + PIX_LATENCY + 1, inst, e, name});
        @(negedge clk);
    endtask

    // unscaled instance: glyph position k, glyph pixel (gx, gy)
    task automatic pg(input int k, input int gx, input int gy, input bit e, input string name);
        pix(0, X0 + k * 24 + gx, Y0 + gy, e, $sformatf("%s_k%0d", name, k));
    endtask

    task automatic drain();
        repeat (PIX_LATENCY + 2) @(negedge clk);
        h = 11'd0;
        v = 10'd0;
    endtask

    task automatic do_load(input int value, input bit push, input int expv);
        val  = 14'(value);
        load = 1'b1;
        if (push) cq.push_back(expv);
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 200; i++) begin
            if (!busy0 && cq.size() == 0) break;
            @(negedge clk);
        end
        check("conv_drained", cq.size(), 0);
        check("busy_idle", int'(busy0), 0);
        check("busy_idle_s1", int'(busy1), 0);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        rst_n = 1'b0;
        x = 11'(X0);
        y = 10'(Y0);
        h = 11'd0;
        v = 10'd0;
        val = '0;
        load = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_busy", int'(busy0), 0);
        check("reset_draw", int'(draw0), 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // "0000" after reset, unscaled
        pix(0, X0, Y0 + 12, !LZB, "rst_glyph0_r12c0");
        for (int hh = 96; hh <= 104; hh++)
            pix(0, hh, Y0 + 12, (hh >= 100 && hh <= 102) ? !LZB : 1'b0, $sformatf("edge_h%0d", hh));
        pg(0, 12, 1, !LZB, "rst_top");
        pg(0, 12, 11, 1'b0, "rst_mid");
        pix(0, X0 + 95, Y0 + 12, 1'b1, "right_dx95");
        pix(0, X0 + 96, Y0 + 12, 1'b0, "right_dx96");
        pix(0, X0 + 84, Y0 + 23, 1'b1, "bottom_dy23");
        pix(0, X0 + 84, Y0 + 24, 1'b0, "bottom_dy24");
        pix(0, X0 + 84, Y0 - 1, 1'b0, "above_dy_m1");
        // "0000" scaled by 2
        pix(1, X0 + 191, Y0 + 24, 1'b1, "s2_dx191");
        pix(1, X0 + 192, Y0 + 24, 1'b0, "s2_dx192");
        pix(1, X0, Y0 + 24, !LZB, "s2_dx0_dy24");
        pix(1, X0 + 1, Y0 + 25, !LZB, "s2_dx1_dy25");
        pix(1, X0 + 6, Y0 + 24, 1'b0, "s2_dx6_dy24");
        pix(1, X0 + 168, Y0 + 47, 1'b1, "s2_dy47");
        pix(1, X0 + 168, Y0 + 48, 1'b0, "s2_dy48");
        drain();

        // 1234
        do_load(1234, 1'b1, 1234);
        wait_idle();
        pg(0, 12, 1, 1'b0, "v1234_top");
        pg(1, 12, 1, 1'b1, "v1234_top");
        pg(2, 12, 1, 1'b1, "v1234_top");
        pg(3, 12, 1, 1'b0, "v1234_top");
        pg(0, 12, 11, 1'b0, "v1234_mid");
        pg(1, 12, 11, 1'b1, "v1234_mid");
        pg(2, 12, 11, 1'b1, "v1234_mid");
        pg(3, 12, 11, 1'b1, "v1234_mid");
        pg(0, 1, 15, 1'b0, "v1234_lowleft");
        pg(1, 1, 15, 1'b1, "v1234_lowleft");
        pg(2, 1, 15, 1'b0, "v1234_lowleft");
        pg(3, 1, 15, 1'b0, "v1234_lowleft");
        for (int k = 0; k < 4; k++) pg(k, 22, 5, 1'b1, "v1234_upright");
        drain();

        // overflow saturates to 9999
        do_load(12000, 1'b1, 9999);
        wait_idle();
        for (int k = 0; k < 4; k++) pg(k, 12, 11, 1'b1, "v9999_mid");
        for (int k = 0; k < 4; k++) pg(k, 1, 15, 1'b0, "v9999_lowleft");
        drain();

        // back-to-back: 5678 is overwritten by 42 while 1111 converts
        do_load(1111, 1'b1, 1111);
        repeat (3) @(negedge clk);
        do_load(5678, 1'b0, 0);
        repeat (3) @(negedge clk);
        do_load(42, 1'b1, 42);
        wait_idle();
        pg(0, 12, 1, !LZB, "v0042_top");
        pg(1, 12, 1, !LZB, "v0042_top");
        pg(2, 12, 1, 1'b0, "v0042_top");
        pg(3, 12, 1, 1'b1, "v0042_top");
        pg(0, 12, 11, 1'b0, "v0042_mid");
        pg(1, 12, 11, 1'b0, "v0042_mid");
        pg(2, 12, 11, 1'b1, "v0042_mid");
        pg(3, 12, 11, 1'b1, "v0042_mid");
        drain();

        // 7: zero padded, or a single glyph with blanking
        do_load(7, 1'b1, 7);
        wait_idle();
        pg(0, 12, 1, !LZB, "v0007_top");
        pg(1, 12, 1, !LZB, "v0007_top");
        pg(2, 12, 1, !LZB, "v0007_top");
        pg(3, 12, 1, 1'b1, "v0007_top");
        pg(0, 1, 5, !LZB, "v0007_upleft");
        pg(1, 1, 5, !LZB, "v0007_upleft");
        pg(2, 1, 5, !LZB, "v0007_upleft");
        pg(3, 1, 5, 1'b0, "v0007_upleft");

        // reset during a conversion with a pending request, pixel lit
        pg(3, 12, 1, 1'b1, "pre_reset_lit");
        repeat (PIX_LATENCY + 2) @(negedge clk);
        do_load(3333, 1'b0, 0);
        repeat (3) @(negedge clk);
        do_load(4444, 1'b0, 0);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_busy", int'(busy0), 0);
        check("midrst_draw", int'(draw0), 0);
        repeat (3) @(negedge clk);
        check("midrst_digits", disp_value(), 0);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check("no_restart_busy", int'(busy0), 0);
        check("no_restart_digits", disp_value(), 0);
        pg(3, 12, 1, 1'b1, "post_rst_top");
        pg(0, 12, 1, !LZB, "post_rst_top");
        pg(3, 12, 11, 1'b0, "post_rst_mid");
        drain();

        check("pix_queue_empty", pq.size(), 0);
        check("conv_queue_empty", cq.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/number_display_sprite.md
Name: number_display_sprite

Overview:
- Renders an unsigned binary value as DIGITS decimal glyphs, drawn left-to-right from (x_in, y_in), for the video overlay path.
- Converts the value to BCD with a sequential double-dabble FSM on each load request.
- Looks up glyph pixels in a 1-bit single-port BROM (numbers.mem, glyphs 0-9 stacked).
- Glyphs can be enlarged by an integer power-of-two scale, and draw_out is pipeline-aligned to the input counters.

Parameters:
- DIGITS, 4, number of displayed decimal digits (1..8).
- VALUE_W, 14, width of value_in in bits.
- GLYPH_W, 24, glyph width in ROM pixels.
- GLYPH_H, 24, glyph height in ROM pixels.
- NUM_GLYPHS, 10, glyphs stored in the ROM.
- SCALE_LOG2, 0, on-screen magnification is 2^SCALE_LOG2 in both axes.

Ports:
- pixel_clk_in  in  1  pixel clock.
- rst_n_in  in  1  reset.
- x_in  in  11  left edge of the digit field.
- y_in  in  10  top edge of the digit field.
- hcount_in  in  11  current pixel column.
- vcount_in  in  10  current pixel row.
- value_in  in  VALUE_W  value to display.
- load_in  in  1  single-cycle request to latch value_in and convert it.
- busy_out  out  1  conversion in progress.
- draw_out  out  1  glyph pixel set at the pipelined position.

Behaviour:
- Interface: one clock, pixel_clk_in. Reset rst_n_in is asynchronous and active-low.
- Reset values: draw_out=0; busy_out=0; displayed BCD digits=0 (the field shows "0000"); FSM in IDLE; pending flag=0.
- FSM states:
  - IDLE: on load_in, capture value_in into the shift register, clear the BCD accumulator, go to SHIFT.
  - SHIFT: runs exactly VALUE_W cycles. Each cycle: add 3 to every BCD nibble >=5, then shift left 1 bit.
  - DONE: one cycle. Copies the accumulator into the displayed-digit register atomically, then returns to IDLE.
- busy_out=1 in SHIFT and DONE. A conversion takes VALUE_W+1 cycles after the load_in cycle.
- load_in while busy: value_in is stored in a one-deep pending register; the last request wins. IDLE restarts immediately from the pending value.
- load_in in the DONE cycle counts as pending.
- Overflow: if the latched value >= 10^DIGITS, every displayed digit is 9.
- Displayed digits never change mid-conversion, so there is no tearing within a frame.
- Pixel pipeline, stage 0 (combinational):
  - dx = hcount_in - x_in; dy = vcount_in - y_in.
  - Digit index k comes from DIGITS parallel compares of dx against k*(GLYPH_W<<SCALE_LOG2). No divider.
  - gx = (dx - k*(GLYPH_W<<SCALE_LOG2)) >> SCALE_LOG2; gy = dy >> SCALE_LOG2.
  - addr = digit[k]*GLYPH_W*GLYPH_H + gy*GLYPH_W + gx.
  - in_field = hcount_in >= x_in && dx < DIGITS*(GLYPH_W<<SCALE_LOG2) && vcount_in >= y_in && dy < GLYPH_H<<SCALE_LOG2.
- Stage 1: addr and in_field are registered.
- BROM is HIGH_PERFORMANCE with 2-cycle read latency.
- draw_out = in_field_d3 && rom_bit, registered on the output edge.
- Total latency: draw_out at cycle t+3 reflects hcount_in/vcount_in sampled at cycle t. x_in/y_in are sampled at stage 0 only.
- Outside the field, addr is forced to 0 and draw_out=0 regardless of ROM contents.
- Address width is clog2(GLYPH_W*GLYPH_H*NUM_GLYPHS). Intermediate products are sized so they never truncate.
- Reset mid-conversion: FSM returns to IDLE, the pending value is dropped, and displayed digits clear to 0.

Optional Feature:
- Macro: NUMDISP_LZB_EN (leading-zero blanking).
- Defined: leading zero digits are not drawn. The least significant digit is always drawn, so a value of 0 shows a single "0" in the rightmost position.
- Blank mask is computed in DONE and registered with the digits.
- Undefined: all DIGITS glyphs are drawn, zero-padded.

Decomposition:
- Package numdisp_pkg holds:
  - ROM_LATENCY=2 and PIX_LATENCY=3.
  - The FSM state enum typedef (IDLE, SHIFT, DONE).
  - bcd_digit_t (logic [3:0]).
  - A function returning the clog2 address width.
- Sub-module bin_to_bcd_seq: parametrised on VALUE_W and DIGITS. Owns the FSM, pending register and saturation; outputs the digit array and busy.
- Top level owns the pixel pipeline and the BROM instance.

Test Plan:
- Reset: rst_n_in low mid-frame → draw_out=0 and busy_out=0 immediately. After release, field shows "0000"; pixel (x_in, y_in+12) matches ROM glyph 0 row 12, col 0.
- Load: value_in=1234, load_in pulse → busy_out high for exactly 15 cycles. Digits become 1,2,3,4 in the DONE cycle. Rendered pixels match ROM glyphs 1..4 at dx offsets 0/24/48/72.
- Latency: sweep hcount across the field edge x_in=100 → first possible draw_out=1 occurs 3 cycles after hcount_in=100. hcount_in=99 never produces draw_out.
- Overflow and back-to-back: value_in=12000 → "9999". load_in 5678 then 42 while busy → final display 0042. 5678 is never shown because pending is overwritten.
- Scale: SCALE_LOG2=1 → each ROM pixel covers a 2x2 block; field is 192x48 pixels. dx=191 is drawn per the ROM and dx=192 gives draw_out=0.
- NUMDISP_LZB_EN: value 7 → only the rightmost glyph drawn, digits 0-2 blank. Without the macro, renders "0007".
